// File: rtl/div_32bit.sv
// 32-bit unsigned restoring divider: one quotient bit per clock, MSB first.
// Divide-by-zero skips the iteration and reports all-ones with the dividend as remainder.

module div_32bit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        div_by_zero
);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] dvsr_q, dvsr_d;
   logic [31:0] work_q, work_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] remo_q, remo_d;
   logic        dbz_q, dbz_d;

   logic [32:0] add_a;
   logic [32:0] add_b;
   logic [31:0] add_s;
   logic [33:0] carry;
   logic        qbit;
   logic [31:0] rem_next;
   logic [31:0] work_next;

   // Trial subtraction partial - divisor as a ripple-carry add of the one's complement plus one.
   always_comb begin
      add_a    = {rem_q, work_q[31]};
      add_b    = ~{1'b0, dvsr_q};
      carry    = '0;
      carry[0] = 1'b1;
      add_s    = '0;
      for (int i = 0; i < 32; i++) begin
         add_s[i]     = add_a[i] ^ add_b[i] ^ carry[i];
         carry[i + 1] = (add_a[i] & add_b[i]) | (carry[i] & (add_a[i] ^ add_b[i]));
      end
      carry[33] = (add_a[32] & add_b[32]) | (carry[32] & (add_a[32] ^ add_b[32]));
   end

   // Carry-out set means the difference is non-negative; partial < 2*divisor keeps it in 32 bits.
   always_comb begin
      qbit      = carry[33];
      rem_next  = qbit ? add_s : add_a[31:0];
      work_next = {work_q[30:0], qbit};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvsr_d  = dvsr_q;
      work_d  = work_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      remo_d  = remo_q;
      dbz_d   = dbz_q;

      unique case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (start) begin
               if (divisor == 32'd0) begin
                  state_d = StDone;
                  quo_d   = 32'hFFFF_FFFF;
                  remo_d  = dividend;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = StRun;
                  dvsr_d  = divisor;
                  work_d  = dividend;
                  rem_d   = 32'd0;
                  cnt_d   = 6'd0;
               end
            end
         end
         StRun: begin
            rem_d  = rem_next;
            work_d = work_next;
            cnt_d  = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               state_d = StDone;
               quo_d   = work_next;
               remo_d  = rem_next;
               dbz_d   = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 6'd0;
         dvsr_q  <= 32'd0;
         work_q  <= 32'd0;
         rem_q   <= 32'd0;
         quo_q   <= 32'd0;
         remo_q  <= 32'd0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvsr_q  <= dvsr_d;
         work_q  <= work_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         remo_q  <= remo_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      busy        = (state_q == StRun);
      done        = (state_q == StDone);
      quotient    = quo_q;
      remainder   = remo_q;
      div_by_zero = dbz_q;
   end

endmodule

// File: tb/tb_div_32bit.sv
// Directed and random back-to-back checks of div_32bit against hand values and a / % model.

module tb_div_32bit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int checks = 0;
   int errors = 0;

   div_32bit dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Entered at a negedge with the DUT in IDLE or DONE; returns at the negedge of the done cycle.
   task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq,
                         input logic [31:0] er, input logic edbz, input int poke);
      int lat;
      int nbusy;
      int first_busy;
      int overlap;
      lat        = 0;
      nbusy      = 0;
      first_busy = 0;
      overlap    = 0;
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (busy && done) overlap++;
         if (busy) begin
            nbusy++;
            if (first_busy == 0) first_busy = n;
         end
         if (done) begin
            lat = n;
            break;
         end
         start = (n == poke);
         if (n == poke) begin
            dividend = 32'd999;
            divisor  = 32'd3;
         end
      end
      start = 1'b0;
      check_eq("latency", lat, (b == 32'd0) ? 32'd1 : 32'd33);
      check_eq("busy_cycles", nbusy, (b == 32'd0) ? 32'd0 : 32'd32);
      check_eq("first_busy", first_busy, (b == 32'd0) ? 32'd0 : 32'd1);
      check_eq("busy_done_overlap", overlap, 32'd0);
      check_eq("quotient", quotient, eq);
      check_eq("remainder", remainder, er);
      check_eq("div_by_zero", {31'd0, div_by_zero}, {31'd0, edbz});
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      int          pulses;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = 32'd0;
      divisor  = 32'd0;
      repeat (2) @(negedge clk);
      check_eq("reset_busy", {31'd0, busy}, 32'd0);
      check_eq("reset_done", {31'd0, done}, 32'd0);
      check_eq("reset_quotient", quotient, 32'd0);
      check_eq("reset_remainder", remainder, 32'd0);
      check_eq("reset_dbz", {31'd0, div_by_zero}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      do_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);
      do_div(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
      do_div(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 0);
      do_div(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 0);
      do_div(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
      // Leave DONE for IDLE, then confirm results hold there.
      @(negedge clk);
      check_eq("hold_quotient", quotient, 32'hFFFF_FFFF);
      check_eq("hold_dbz", {31'd0, div_by_zero}, 32'd1);
      // Start in cycle 10 of a run must be ignored.
      do_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 10);
      @(negedge clk);

      // Reset in cycle 20 of a run.
      start    = 1'b1;
      dividend = 32'd1000;
      divisor  = 32'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (20) @(negedge clk);
      check_eq("midrun_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_quotient", quotient, 32'd0);
      check_eq("rst_remainder", remainder, 32'd0);
      check_eq("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      pulses = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      check_eq("rst_no_activity", pulses, 32'd0);

      // Reset wins over a simultaneous start.
      rst      = 1'b1;
      start    = 1'b1;
      dividend = 32'd50;
      divisor  = 32'd5;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      check_eq("rst_prio_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_prio_done", {31'd0, done}, 32'd0);
      do_div(32'd1000, 32'd9, 32'd111, 32'd1, 1'b0, 0);

      // Random back-to-back: each new start lands in the previous DONE cycle.
      for (int k = 0; k < 1000; k++) begin
         a = $urandom;
         if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 255);
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       b = a;
            3:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         if (b == 32'd0) do_div(a, b, 32'hFFFF_FFFF, a, 1'b1, 0);
         else            do_div(a, b, a / b, a % b, 1'b0, 0);
      end
      @(negedge clk);
      check_eq("final_idle_done", {31'd0, done}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_32bit.md
DIV_32BIT -- requirements
Module: div_32bit

Interface
REQ-001 The module SHALL have no parameters; data width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request a division; sampled only when busy=0.
REQ-005 dividend  input  32  unsigned dividend; captured in the cycle start is accepted.
REQ-006 divisor  input  32  unsigned divisor; captured in the cycle start is accepted.
REQ-007 busy  output  1  high while iterations are in progress.
REQ-008 done  output  1  one-cycle pulse; results valid in that cycle.
REQ-009 quotient  output  32  unsigned quotient, registered.
REQ-010 remainder  output  32  unsigned remainder, registered.
REQ-011 div_by_zero  output  1  high with results when the captured divisor was 0.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-013 Restoring shift-subtract algorithm, one quotient bit per clock, MSB first.
REQ-014 Per RUN step: 33-bit partial remainder = {rem[31:0], next dividend bit}. Trial subtraction = partial + ~{1'b0,divisor} + 1 through a carry-chain adder. Carry-out 1 means non-negative: keep the difference and shift in quotient bit 1. Otherwise restore the partial remainder and shift in 0.
REQ-015 A 6-bit step counter SHALL count 0..31 in RUN. After step 31 the FSM enters DONE.
REQ-016 start is accepted when start=1 in IDLE or DONE. Define the accept cycle as cycle 0.
REQ-017 On accept with divisor!=0: operands captured, partial remainder cleared, state goes to RUN. busy=1 in cycles 1..32. done=1 in cycle 33. Total latency is 33 cycles.
REQ-018 On accept with divisor==0: no RUN state. done=1 and div_by_zero=1 in cycle 1. quotient=32'hFFFFFFFF, remainder=dividend. busy stays 0.
REQ-019 start while busy=1 SHALL be ignored. Operands and progress SHALL be unaffected.
REQ-020 quotient, remainder and div_by_zero SHALL update only in the cycle done rises. They SHALL hold until the next done pulse or reset.
REQ-021 div_by_zero SHALL be 0 for any completed division with a non-zero divisor.
REQ-022 DONE lasts one cycle. It returns to IDLE, or goes to RUN/DONE if start=1 in that cycle (back-to-back). The outputs of the previous result remain valid in that cycle.
REQ-023 done and busy SHALL never be high in the same cycle.
REQ-024 Results SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor for all divisor != 0.

Reset
REQ-025 When rst=1 at a clock edge, the module SHALL enter IDLE, regardless of state, including mid-RUN.
REQ-026 That reset edge SHALL also clear the step counter and internal registers, and set busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
REQ-027 rst SHALL take priority over start in the same cycle.
REQ-028 After rst deasserts, the first accepted start SHALL behave exactly as from power-up IDLE.

Verification
REQ-029 dividend=100, divisor=7, start pulse -> busy cycles 1..32; done in cycle 33; quotient=14, remainder=2, div_by_zero=0.
REQ-030 dividend=32'hFFFFFFFF, divisor=1 -> quotient=32'hFFFFFFFF, remainder=0, done in cycle 33.
REQ-031 dividend=3, divisor=10 -> quotient=0, remainder=3. Then dividend=32'h80000000, divisor=32'hFFFFFFFF -> quotient=0, remainder=32'h80000000.
REQ-032 dividend=5, divisor=0 -> done and div_by_zero in cycle 1; quotient=32'hFFFFFFFF, remainder=5; busy never high.
REQ-033 Mid-operation events:
- start with new operands in cycle 10 of a run -> ignored; first result is correct.
- rst in cycle 20 -> next cycle IDLE, all outputs 0, no done pulse.
REQ-034 Random back-to-back run: start asserted in each DONE cycle, 1000 random operand pairs including divisor 0 -> every result matches the reference model per REQ-024/REQ-018.
